// File: rtl/prog_timer_pkg.sv
// Shared constants for the programmable timer: FSM state encoding and mode encoding.
// The encodings match the legacy timer so existing register dumps still decode.
package prog_timer_pkg;

  typedef logic [0:0] state_t;
  typedef logic       mode_t;

  localparam state_t StIdle = 1'b0;
  localparam state_t StRun  = 1'b1;

  localparam mode_t ModeOneshot  = 1'b0;
  localparam mode_t ModePeriodic = 1'b1;

endpackage

// File: rtl/prog_timer_if.sv
// Control/status bundle of the programmable timer.
//   master : drives count_en, load, stop, mode, load_value, prescale; observes count/busy/done
//   slave  : the timer side of the same signals
interface prog_timer_if #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned PSC_W = 4
);

  logic             count_en;
  logic             load;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] load_value;
  logic [PSC_W-1:0] prescale;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output count_en, load, stop, mode, load_value, prescale,
    input  count, busy, done
  );

  modport slave (
    input  count_en, load, stop, mode, load_value, prescale,
    output count, busy, done
  );

endinterface

// File: rtl/prog_timer_tick_prescaler.sv
// Prescaler for the programmable timer. Produces one tick every max+1 enabled cycles.
//   clock, reset : system clock, synchronous active-high reset
//   en           : advance the prescaler this cycle
//   clr          : restart the prescale period (wins over en)
//   max          : terminal prescaler value
//   tick         : combinational, high on the enabled cycle that completes a period
module prog_timer_tick_prescaler #(
  parameter int unsigned PSC_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [PSC_W-1:0] max,
  output logic             tick
);

  logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;

  assign tick = en & (psc_cnt_q == max);

  always_comb begin
    psc_cnt_d = psc_cnt_q;
    if (clr || tick) begin
      psc_cnt_d = '0;
    end else if (en) begin
      psc_cnt_d = psc_cnt_q + PSC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      psc_cnt_q <= '0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
    end
  end

endmodule

// File: rtl/prog_timer.sv
// Down-counting timer with prescaler, one-shot/periodic mode, restart and abort.
// Emits a registered single-cycle done pulse on expiry.
//   clock, reset : system clock, synchronous active-high reset (overrides everything)
//   bus (slave)  : count_en, load, stop, mode, load_value, prescale in;
//                  count, busy, done out
// Per-cycle priority: reset > load > stop > tick.
module prog_timer
  import prog_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned PSC_W = 4
) (
  input  logic        clock,
  input  logic        reset,
  prog_timer_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PSC_W-1:0] psc_max_q, psc_max_d;
  mode_t            mode_q, mode_d;
  logic             done_q, done_d;
  logic             tick;

  // load and stop both restart the prescale period.
  prog_timer_tick_prescaler #(
    .PSC_W(PSC_W)
  ) u_prescaler (
    .clock(clock),
    .reset(reset),
    .en   ((state_q == StRun) & bus.count_en),
    .clr  (bus.load | bus.stop),
    .max  (psc_max_q),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    psc_max_d = psc_max_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    if (bus.load) begin
      count_d   = bus.load_value;
      reload_d  = bus.load_value;
      psc_max_d = bus.prescale;
      mode_d    = bus.mode;
      if (bus.load_value != '0) begin
        state_d = StRun;
      end else begin
        // Zero period expires immediately, in either mode.
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end else if (bus.stop) begin
      state_d = StIdle;
    end else if (tick) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        done_d = 1'b1;
        if (mode_q == ModePeriodic) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = StIdle;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      reload_q  <= '0;
      psc_max_q <= '0;
      mode_q    <= ModeOneshot;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      psc_max_q <= psc_max_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state_q == StRun);
  assign bus.done  = done_q;

endmodule

// File: tb/tb_prog_timer.sv
// Directed bench for prog_timer. Expected done cycles are queued when a load is driven and
// matched against observed done pulses every cycle.
module tb_prog_timer;

  localparam int unsigned WIDTH = 9;
  localparam int unsigned PSC_W = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  prog_timer_if #(.WIDTH(WIDTH), .PSC_W(PSC_W)) bus ();

  prog_timer #(
    .WIDTH(WIDTH),
    .PSC_W(PSC_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance one cycle, sample after the edge and reconcile done with the scoreboard.
  task automatic step();
    int e;
    @(posedge clock);
    #1;
    cyc++;
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'(bus.done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", cyc, e);
      end
    end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
      void'(exp_q.pop_front());
      chk("missing_done", 32'(bus.done), 32'd1);
    end
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Load a new run; queue reps expected done cycles (0 = caller queues its own).
  task automatic do_load(input int n, input int p, input logic m, input int reps);
    int t0;
    exp_q.delete();
    bus.load       = 1'b1;
    bus.load_value = WIDTH'(n);
    bus.prescale   = PSC_W'(p);
    bus.mode       = m;
    t0             = cyc;
    if (n == 0) begin
      exp_q.push_back(t0 + 1);
    end else begin
      for (int r = 1; r <= reps; r++) exp_q.push_back(t0 + r * n * (p + 1) + 1);
    end
    step();
    bus.load = 1'b0;
  endtask

  task automatic do_stop();
    exp_q.delete();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  initial begin
    int t3;
    bus.count_en   = 1'b1;
    bus.load       = 1'b0;
    bus.stop       = 1'b0;
    bus.mode       = 1'b0;
    bus.load_value = '0;
    bus.prescale   = '0;

    // Reset state
    steps(2);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    steps(1);

    // 1: one-shot N=5, P=0 -> done at cycle 6
    do_load(5, 0, 1'b0, 1);
    for (int k = 1; k <= 5; k++) begin
      chk("t1_busy", 32'(bus.busy), 32'd1);
      chk("t1_count", 32'(bus.count), 32'(6 - k));
      step();
    end
    chk("t1_busy_after", 32'(bus.busy), 32'd0);
    chk("t1_count_after", 32'(bus.count), 32'd0);
    steps(3);

    // 2: periodic N=2, P=3 -> done at 9, 17, 25
    do_load(2, 3, 1'b1, 3);
    steps(8);
    chk("t2_reload_9", 32'(bus.count), 32'd2);
    chk("t2_busy_9", 32'(bus.busy), 32'd1);
    steps(16);
    chk("t2_reload_25", 32'(bus.count), 32'd2);
    steps(3);
    do_stop();
    chk("t2_busy_stop", 32'(bus.busy), 32'd0);
    steps(8);

    // 3: one-shot N=4 with count_en low for 3 cycles -> done at cycle 8
    t3 = cyc;
    do_load(4, 0, 1'b0, 0);
    exp_q.push_back(t3 + 8);
    step();
    bus.count_en = 1'b0;
    steps(3);
    chk("t3_frozen", 32'(bus.count), 32'd3);
    bus.count_en = 1'b1;
    steps(3);
    chk("t3_busy_after", 32'(bus.busy), 32'd0);
    steps(2);

    // 4: N=10 restarted with N=3 at cycle 4 -> only done at cycle 8
    do_load(10, 0, 1'b0, 1);
    steps(3);
    do_load(3, 0, 1'b0, 1);
    steps(3);
    steps(6);
    chk("t4_busy_after", 32'(bus.busy), 32'd0);

    // Load on the expiry cycle cancels the old done
    do_load(2, 0, 1'b0, 1);
    step();
    do_load(1, 0, 1'b0, 1);
    step();
    chk("coll_busy_after", 32'(bus.busy), 32'd0);
    steps(3);

    // 5: N=6 stopped at cycle 3 -> count frozen at 4, no done
    do_load(6, 0, 1'b0, 1);
    steps(2);
    do_stop();
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_count", 32'(bus.count), 32'd4);
    steps(10);
    chk("t5_count_late", 32'(bus.count), 32'd4);

    // 6: N=0 gives one done next cycle, never busy (both modes)
    do_load(0, 0, 1'b0, 1);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    steps(3);
    chk("t6_done_once", 32'(bus.done), 32'd0);
    do_load(0, 2, 1'b1, 1);
    chk("t6p_busy", 32'(bus.busy), 32'd0);
    steps(4);
    chk("t6p_busy_late", 32'(bus.busy), 32'd0);

    // Reset mid-run clears everything and drops pending done
    do_load(5, 0, 1'b1, 3);
    steps(2);
    reset = 1'b1;
    exp_q.delete();
    step();
    chk("mrst_count", 32'(bus.count), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    steps(12);
    chk("mrst_busy_late", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
